// File: rtl/mid_test_sequencer.sv
// mid_test_sequencer: runs each unit under test in turn (reset, start, wait for done or timeout).
// Optional build macro SEQ_STOP_ON_FAIL_EN: end the sequence at the first failing unit.
module mid_test_sequencer #(
  parameter int N_UNITS    = 3,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1000,
  parameter int CNT_W      = 16,
  localparam int IDXW      = ($clog2(N_UNITS) < 1) ? 1 : $clog2(N_UNITS)
) (
  input  logic               clk,
  input  logic               rstn1,
  input  logic               go,
  input  logic [N_UNITS-1:0] unit_done,
  input  logic [N_UNITS-1:0] unit_pass,
  output logic [N_UNITS-1:0] unit_rstn,
  output logic [N_UNITS-1:0] unit_start,
  output logic [IDXW-1:0]    cur_unit,
  output logic               busy,
  output logic [N_UNITS-1:0] pass_vec,
  output logic [N_UNITS-1:0] timeout_vec,
  output logic               all_pass,
  output logic               seq_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_START,
    S_WAIT,
    S_NEXT,
    S_FIN
  } state_t;

  state_t state;
  state_t state_n;

  logic [CNT_W-1:0]   cnt;
  logic [N_UNITS-1:0] sel;
  logic               last;
  logic               cur_done;
  logic               cur_pass;
  logic               rst_end;
  logic               tmo;

  assign sel      = {{(N_UNITS-1){1'b0}}, 1'b1} << cur_unit;
  assign last     = (cur_unit == IDXW'(N_UNITS - 1));
  assign cur_done = unit_done[cur_unit];
  assign cur_pass = unit_pass[cur_unit];
  assign rst_end  = (cnt == CNT_W'(RST_CYCLES - 1));
  assign tmo      = (cnt == CNT_W'(TIMEOUT - 1));

`ifdef SEQ_STOP_ON_FAIL_EN
  logic cur_ok;
  assign cur_ok = pass_vec[cur_unit];
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn1) begin
    if (!rstn1) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_n    = state;
    unit_rstn  = '0;
    unit_start = '0;
    busy       = (state != S_IDLE);
    seq_done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (go) state_n = S_RST;
      end
      S_RST: begin
        if (rst_end) state_n = S_START;
      end
      S_START: begin
        unit_rstn  = sel;
        unit_start = sel;
        state_n    = S_WAIT;
      end
      S_WAIT: begin
        unit_rstn = sel;
        if (cur_done || tmo) state_n = S_NEXT;
      end
      S_NEXT: begin
        state_n = S_RST;
        if (last) state_n = S_FIN;
`ifdef SEQ_STOP_ON_FAIL_EN
        if (!cur_ok) state_n = S_FIN;
`endif
      end
      S_FIN: begin
        seq_done = 1'b1;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Counter, unit index and result registers.
  always_ff @(posedge clk or negedge rstn1) begin
    if (!rstn1) begin
      cnt         <= '0;
      cur_unit    <= '0;
      pass_vec    <= '0;
      timeout_vec <= '0;
      all_pass    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) begin
            cnt         <= '0;
            cur_unit    <= '0;
            pass_vec    <= '0;
            timeout_vec <= '0;
            all_pass    <= 1'b0;
          end
        end
        S_RST: cnt <= cnt + 1'b1;
        S_START: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cur_done) begin
            pass_vec[cur_unit] <= cur_pass;
          end else if (tmo) begin
            timeout_vec[cur_unit] <= 1'b1;
            pass_vec[cur_unit]    <= 1'b0;
          end
        end
        S_NEXT: begin
          if (state_n == S_RST) begin
            cur_unit <= cur_unit + 1'b1;
            cnt      <= '0;
          end
        end
        S_FIN: all_pass <= &pass_vec;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mid_test_sequencer.md
Name: mid_test_sequencer

Overview:
Clocked scheduler that runs a set of units under test one at a time inside the midterm system.
- For each unit in turn: hold it in reset, release it, pulse start, then wait for done or a timeout.
- Latches a per-unit pass/timeout result and raises one aggregate pass flag at the end.
- Replaces fixed-delay phase sequencing in the top level with handshake-driven sequencing.

Parameters:
N_UNITS, 3, number of units sequenced (2..8)
RST_CYCLES, 2, cycles each unit is held in reset before start (>=1)
TIMEOUT, 1000, max WAIT cycles per unit before declaring timeout (>=1)
CNT_W, 16, cycle counter width; must hold max(RST_CYCLES, TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rstn1  in  1  reset, asynchronous assert, active-low
go  in  1  start a full sequence; sampled in IDLE only
unit_done  in  N_UNITS  per-unit completion level/pulse
unit_pass  in  N_UNITS  per-unit result, valid with unit_done
unit_rstn  out  N_UNITS  per-unit active-low reset
unit_start  out  N_UNITS  per-unit one-cycle start pulse
cur_unit  out  IDXW  index of unit being run; IDXW = max(1, clog2(N_UNITS))
busy  out  1  high whenever state != IDLE
pass_vec  out  N_UNITS  latched pass bits
timeout_vec  out  N_UNITS  latched timeout bits
all_pass  out  1  AND of pass_vec, updated in FIN
seq_done  out  1  one-cycle pulse at end of sequence

Behaviour:
- One clock; rstn1 low asynchronously forces:
  - state IDLE, counter 0, cur_unit 0
  - unit_rstn all 0 (every unit parked in reset)
  - unit_start, busy, pass_vec, timeout_vec, all_pass and seq_done all 0
- All outputs are Moore decodes of registered state, cur_unit and result registers. No combinational input-to-output path.
- IDLE:
  - go=1 clears pass_vec, timeout_vec and all_pass; sets cur_unit=0 and counter=0; next state RST.
  - go is ignored in every other state.
- RST: unit_rstn[cur_unit]=0. Counter increments; after RST_CYCLES cycles in RST, next state START.
- START:
  - Exactly one cycle. unit_rstn[cur_unit]=1 and unit_start[cur_unit]=1.
  - Counter cleared; next state WAIT.
- WAIT: unit_rstn[cur_unit]=1. Counter increments each cycle. Priority order:
  1. unit_done[cur_unit]=1: pass_vec[cur_unit] <= unit_pass[cur_unit]; next state NEXT.
  2. Otherwise, counter == TIMEOUT-1: timeout_vec[cur_unit] <= 1 and pass_vec[cur_unit] <= 0; next state NEXT.
  - done and timeout in the same cycle: done wins, and timeout_vec stays 0.
  - unit_done/unit_pass bits of non-current units are ignored. unit_done during RST or START is ignored.
- NEXT:
  - unit_rstn[cur_unit] returns to 0.
  - If cur_unit == N_UNITS-1, next state FIN; else cur_unit++, counter=0, next state RST.
- FIN:
  - all_pass <= &pass_vec; seq_done=1 for this single cycle; next state IDLE.
  - pass_vec, timeout_vec and all_pass hold until the next accepted go or reset.
- Timing:
  - go sampled at edge E. busy=1 from E+1. unit_start[0] is high in cycle E+1+RST_CYCLES.
  - Maximum WAIT dwell per unit is exactly TIMEOUT cycles.
- Only one bit of unit_start and at most one bit of unit_rstn are ever high at a time.
- Reset mid-operation aborts immediately with no partial results retained. The next go restarts from unit 0.

Optional Feature:
Macro SEQ_STOP_ON_FAIL_EN.
- Defined: in NEXT, if pass_vec[cur_unit]==0 (fail or timeout), go directly to FIN. Remaining units stay in reset and their pass/timeout bits stay 0; all_pass=0.
- Undefined: every unit is always run regardless of earlier failures.

Test Plan:
- Reset: hold rstn1=0 mid-WAIT of unit 1 -> same cycle: unit_rstn=000, unit_start=000, busy=0, pass_vec=000, timeout_vec=000. After release, go restarts at unit 0.
- All pass (N=3, RST_CYCLES=2): go at edge E; each unit returns done=1, pass=1 five cycles after its start -> unit_start pulses 001, 010, 100 in order, the first in cycle E+3; pass_vec=111, all_pass=1, one seq_done pulse, then busy=0.
- Timeout (TIMEOUT=8): unit 1 never asserts done -> unit 1 WAIT lasts exactly 8 cycles; timeout_vec=010, pass_vec=101, all_pass=0.
- Collision: unit 0 asserts done=1, pass=1 on the cycle counter reaches TIMEOUT-1 -> pass_vec[0]=1, timeout_vec[0]=0.
- Spurious inputs: go pulsed during WAIT, unit_done[2]=1 during unit 0 WAIT, unit_done[0]=1 during RST -> no state, index or result change.
- SEQ_STOP_ON_FAIL_EN defined, unit 0 reports pass=0 -> FIN directly after unit 0; unit_start[1] and unit_start[2] never pulse; pass_vec=000, all_pass=0.
